// File: rtl/cpu_pkg.sv
// Shared branch-control definitions: funct3 codes and redirect FSM states.
// Imported by branch_cond_eval and branch_redirect_ctrl.
package cpu_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    HOLD     = 2'd2
  } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition from funct3 and ALU flags (Z/N/C/V).
// Ports: funct3, four flags in; cond (taken), illegal (funct3 010/011) out.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero_flag,
  input  logic       sign_flag,
  input  logic       carry_flag,
  input  logic       overf_flag,
  output logic       cond,
  output logic       illegal
);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond = zero_flag;
      F3_BNE:  cond = ~zero_flag;
      F3_BLT:  cond = sign_flag ^ overf_flag;
      F3_BGE:  cond = ~(sign_flag ^ overf_flag);
      // C is the no-borrow flag of a-b, so C=1 means a >= b unsigned
      F3_BLTU: cond = ~carry_flag;
      F3_BGEU: cond = carry_flag;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage redirect sequencer: PC select/target, pipeline flushes, stats.
// Ports: clk/rst, stall, EX branch info + ALU flags in; pc_src, pc_target,
// flush_*, illegal_br, busy, br_count, taken_count out.
module branch_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int EXTRA_FLUSH = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic             zero_flag,
  input  logic             sign_flag,
  input  logic             carry_flag,
  input  logic             overf_flag,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             clr_stats,
  output logic             pc_src,
  output logic [XLEN-1:0]  pc_target,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             illegal_br,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [3:0]       HOLD_INIT = 4'(EXTRA_FLUSH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  br_state_e  state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       cond, illegal, take, capture;

  branch_cond_eval u_cond (
    .funct3     (ex_funct3),
    .zero_flag  (zero_flag),
    .sign_flag  (sign_flag),
    .carry_flag (carry_flag),
    .overf_flag (overf_flag),
    .cond       (cond),
    .illegal    (illegal)
  );

  // EX instructions seen outside IDLE are squashed
  assign capture = (state == IDLE) & ex_valid & ~stall;
  assign take    = ex_jump | (ex_branch & cond);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    pc_src       = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture && take) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        pc_src       = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        if (!stall) begin
          if (EXTRA_FLUSH == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            hold_nxt  = HOLD_INIT;
          end
        end
      end
      HOLD: begin
        flush_if_id = 1'b1;
        if (!stall) begin
          hold_nxt = hold_cnt - 4'd1;
          if (hold_cnt == 4'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= 4'd0;
      pc_target  <= '0;
      illegal_br <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      illegal_br <= capture & ex_branch & ~ex_jump & illegal;
      if (capture && take) pc_target <= ex_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (clr_stats) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (capture) begin
      if (ex_branch && br_count != CNT_MAX)
        br_count <= br_count + CNT_ONE;
      if (take && taken_count != CNT_MAX)
        taken_count <= taken_count + CNT_ONE;
    end
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences control-flow redirection for the 5-stage pipeline. It evaluates the EX-stage branch/jump condition from the ALU flags and funct3, registers the decision, and drives the PC select and target. It asserts the IF/ID, ID/EX and EX/MEM flush controls for the required number of cycles, and it keeps saturating branch statistics. The block sits between the ALU flag outputs, the PC mux and the pipeline-register flush inputs.

Parameters:
XLEN, 32, width of the branch target address
EXTRA_FLUSH, 0, extra cycles that flush_if_id stays asserted after the redirect cycle (covers instruction-memory latency); legal range 0..15
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
stall  in  1  pipeline stall; freezes the controller state and counters
ex_valid  in  1  EX stage holds a valid instruction
ex_branch  in  1  EX instruction is a conditional branch
ex_jump  in  1  EX instruction is JAL/JALR (unconditional)
ex_funct3  in  3  inst[14:12] of the EX instruction
zero_flag  in  1  ALU Z
sign_flag  in  1  ALU N
carry_flag  in  1  ALU C
overf_flag  in  1  ALU V
ex_target  in  XLEN  computed branch/jump target
clr_stats  in  1  synchronous clear of the counters
pc_src  out  1  select pc_target at the PC mux
pc_target  out  XLEN  registered redirect target
flush_if_id  out  1  zero the IF/ID register at the next edge
flush_id_ex  out  1  zero the ID/EX register at the next edge
flush_ex_mem  out  1  zero the EX/MEM register at the next edge
illegal_br  out  1  one-cycle pulse: branch with funct3 010/011 captured
busy  out  1  state != IDLE
br_count  out  CNT_W  conditional branches captured
taken_count  out  CNT_W  redirects issued (taken branches + jumps)

Behaviour:
- Reset (async, rst=1): state=IDLE; pc_target=0; counters=0; hold counter=0; all 1-bit outputs=0.
- Condition (combinational):
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: N!=V
  - 101 BGE: N==V
  - 110 BLTU: !C
  - 111 BGEU: C
  - 010/011: not taken, and raise illegal_br.
- take = ex_jump | (ex_branch & cond). ex_jump overrides funct3 and never raises illegal_br.
- Capture: an edge in which state=IDLE, ex_valid=1 and stall=0.
  - If take: pc_target<=ex_target and state<=REDIRECT.
  - Else: state stays IDLE.
  - Latency: EX cycle N, then pc_src/flushes asserted in cycle N+1.
- States:
  - IDLE: all control outputs 0.
  - REDIRECT: pc_src=1, flush_if_id=1, flush_id_ex=1, flush_ex_mem=1. With stall=1, stay in REDIRECT with outputs held. On the first stall=0 cycle:
    - EXTRA_FLUSH=0: go to IDLE.
    - Otherwise: go to HOLD and load the hold counter with EXTRA_FLUSH.
  - HOLD: flush_if_id=1 only. The counter decrements on stall=0 cycles. When the counter is 1 and stall=0, go to IDLE.
- Instructions presented in EX while state!=IDLE are squashed: no capture, no counting, no illegal_br.
- After returning to IDLE, a branch can be captured on the very next edge (back-to-back redirects allowed).
- illegal_br: registered, 1 in the cycle after capture of an illegal funct3; otherwise 0.
- Counters:
  - br_count increments on capture with ex_branch=1, taken or not.
  - taken_count increments on a capture that enters REDIRECT.
  - Both saturate at all-ones.
  - clr_stats has priority over a same-cycle increment. It is not gated by stall.
- Reset mid-REDIRECT/HOLD: immediate return to IDLE with all outputs 0.

Decomposition:
- cpu_pkg holds:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - state encoding IDLE=2'd0, REDIRECT=2'd1, HOLD=2'd2
- Sub-module branch_cond_eval: combinational; inputs funct3 and the four flags; outputs cond and illegal.
- The FSM, target register and counters stay in branch_redirect_ctrl.

Test Plan:
- BEQ, Z=1, ex_target=0x0000_0040, stall=0 -> next cycle: pc_src=1, pc_target=0x40, all three flushes=1, then IDLE. taken_count=1, br_count=1.
- BLT with N=1,V=0 (taken), BGE with N=1,V=0 (not taken), BGEU with C=1 (taken) -> 2 redirects; br_count=3, taken_count=2.
- EXTRA_FLUSH=2, JAL:
  - REDIRECT for 1 cycle, then flush_if_id only for 2 cycles, then busy=0.
  - Repeat with stall=1 for 3 cycles during REDIRECT: outputs held for 3 extra cycles.
- funct3=010 branch -> illegal_br=1 for one cycle, no redirect, br_count+1. A branch valid in EX during REDIRECT -> ignored, counters unchanged.
- Counters preset near max (CNT_W=4, 15 taken branches) -> taken_count holds at 15. clr_stats on the same edge as a taken capture -> count=0.
- rst asserted asynchronously mid-REDIRECT -> pc_src/flushes drop to 0 without a clock edge. Next taken branch after release redirects normally.
